wb_bus_arbiter: RTL
===================

WB_BUS_ARBITER -- requirements
Module: wb_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width of all ports.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, stalled-slave cycles before abort (only used with WB_ARB_TIMEOUT_EN).
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports m0_cyc_i/m1_cyc_i  input  1  master cycle (m0 = instruction side, m1 = data side).
REQ-007 SHALL have ports m0_stb_i/m1_stb_i  input  1  master strobe.
REQ-008 SHALL have ports m0_we_i/m1_we_i  input  1  1 = write, 0 = read.
REQ-009 SHALL have ports m0_adr_i/m1_adr_i  input  ADDR_WIDTH  master address.
REQ-010 SHALL have ports m0_dat_i/m1_dat_i  input  DATA_WIDTH  master write data.
REQ-011 SHALL have ports m0_dat_o/m1_dat_o  output  DATA_WIDTH  read data to master.
REQ-012 SHALL have ports m0_ack_o/m1_ack_o  output  1  acknowledge to master.
REQ-013 SHALL have ports m0_err_o/m1_err_o  output  1  timeout error to master.
REQ-014 SHALL have ports s_cyc_o, s_stb_o, s_we_o  output  1 each  slave-side cycle/strobe/write.
REQ-015 SHALL have port s_adr_o  output  ADDR_WIDTH  slave address.
REQ-016 SHALL have port s_dat_o  output  DATA_WIDTH  slave write data.
REQ-017 SHALL have port s_dat_i  input  DATA_WIDTH  slave read data.
REQ-018 SHALL have port s_ack_i  input  1  slave acknowledge.
REQ-019 SHALL have port grant_o  output  2  one-hot current owner (bit0 = m0, bit1 = m1), 00 when idle.

Function
REQ-020 SHALL implement FSM states IDLE, GNT0, GNT1, ABORT; reset state IDLE.
REQ-021 IDLE: request = mX_cyc_i & mX_stb_i; single request -> GNTx next cycle; no request -> stay.
REQ-022 Simultaneous requests in IDLE SHALL go to the master holding priority pointer; pointer = m0 after reset, moves to the other master on every grant (round-robin).
REQ-023 Grant latency SHALL be exactly 1 cycle from request seen in IDLE to s_cyc_o/s_stb_o high.
REQ-024 In GNTx, s_cyc/s_stb/s_we/s_adr/s_dat SHALL combinationally mirror master x; s_ack_i SHALL route only to mx_ack_o; s_dat_i SHALL drive both mX_dat_o.
REQ-025 Non-granted master SHALL see ack_o = 0 and err_o = 0; its request is held pending, never dropped.
REQ-026 GNTx SHALL persist across multiple stb/ack beats while mx_cyc_i stays high; mx_cyc_i low -> IDLE next cycle.
REQ-027 In IDLE and ABORT, s_cyc_o, s_stb_o, s_we_o SHALL be 0 and s_adr_o, s_dat_o SHALL be 0.
REQ-028 grant_o SHALL be a registered copy of the FSM state (01 GNT0, 10 GNT1, 00 otherwise).
REQ-029 s_ack_i arriving in IDLE or ABORT SHALL be ignored.

Reset
REQ-030 rst high SHALL asynchronously force state IDLE, pointer m0, timeout counter 0, grant_o 00, all ack/err outputs 0, even mid-transaction.
REQ-031 First grant after rst deasserts SHALL follow REQ-021/REQ-022 with no extra wait.

Configuration
REQ-032 Macro WB_ARB_TIMEOUT_EN defined: counter SHALL clear on grant/s_ack_i, increment each GNTx cycle with s_stb_o high and s_ack_i low; at TIMEOUT_CYCLES, mx_err_o pulses 1 cycle, state -> ABORT, held until mx_cyc_i low, then IDLE.
REQ-033 Macro WB_ARB_TIMEOUT_EN undefined: no counter, ABORT unreachable, m0_err_o/m1_err_o tied 0, slave stall waits indefinitely.

Verification
REQ-034 Reset, m0 read adr 0x0000_0100, slave acks 0xDEADBEEF after 2 cycles -> s_stb_o high 1 cycle after request, m0_ack_o=1 with m0_dat_o=0xDEADBEEF, grant_o=01.
REQ-035 Both masters request same cycle after reset -> m0 granted first; after m0 drops cyc, m1 (write 0x8000_0004 data 0x12345678) granted next cycle; next simultaneous request -> m0 again.
REQ-036 m1 holds cyc for 4 stb/ack beats while m0 requests -> m0 never acked, granted only after m1_cyc_i low.
REQ-037 rst asserted while in GNT1 with stb high -> same-edge-independent: s_cyc_o=0, grant_o=00 immediately, m1_ack_o=0.
REQ-038 WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks m0 -> m0_err_o=1 one cycle after 8 stalled cycles, s_cyc_o=0 until m0_cyc_i drops; without macro, same stimulus -> no err, s_cyc_o stays high.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone arbiter: m0 = instruction side, m1 = data side.
// Optional stalled-slave timeout/abort enabled by defining WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_cyc_i,
   input  logic                  m0_stb_i,
   input  logic                  m0_we_i,
   input  logic [ADDR_WIDTH-1:0] m0_adr_i,
   input  logic [DATA_WIDTH-1:0] m0_dat_i,
   output logic [DATA_WIDTH-1:0] m0_dat_o,
   output logic                  m0_ack_o,
   output logic                  m0_err_o,
   input  logic                  m1_cyc_i,
   input  logic                  m1_stb_i,
   input  logic                  m1_we_i,
   input  logic [ADDR_WIDTH-1:0] m1_adr_i,
   input  logic [DATA_WIDTH-1:0] m1_dat_i,
   output logic [DATA_WIDTH-1:0] m1_dat_o,
   output logic                  m1_ack_o,
   output logic                  m1_err_o,
   output logic                  s_cyc_o,
   output logic                  s_stb_o,
   output logic                  s_we_o,
   output logic [ADDR_WIDTH-1:0] s_adr_o,
   output logic [DATA_WIDTH-1:0] s_dat_o,
   input  logic [DATA_WIDTH-1:0] s_dat_i,
   input  logic                  s_ack_i,
   output logic [1:0]            grant_o
);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_GNT0  = 2'b01;
   localparam logic [1:0] S_GNT1  = 2'b10;
   localparam logic [1:0] S_ABORT = 2'b11;

   logic [1:0] r_state;
   logic [1:0] w_next;
   logic       r_ptr;
   logic       r_owner;
   logic [1:0] r_grant;
   logic       w_req0;
   logic       w_req1;
   logic       w_timeout;
   logic       w_owner_cyc;

   assign w_req0      = m0_cyc_i & m0_stb_i;
   assign w_req1      = m1_cyc_i & m1_stb_i;
   assign w_owner_cyc = r_owner ? m1_cyc_i : m0_cyc_i;
   assign m0_dat_o    = s_dat_i;
   assign m1_dat_o    = s_dat_i;
   assign grant_o     = r_grant;

   // Next-state: round-robin pick in IDLE, hold grant while owner keeps cyc
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_req0 && w_req1)
               w_next = r_ptr ? S_GNT1 : S_GNT0;
            else if (w_req0)
               w_next = S_GNT0;
            else if (w_req1)
               w_next = S_GNT1;
         end
         S_GNT0: begin
            if (!m0_cyc_i)
               w_next = S_IDLE;
            else if (w_timeout)
               w_next = S_ABORT;
         end
         S_GNT1: begin
            if (!m1_cyc_i)
               w_next = S_IDLE;
            else if (w_timeout)
               w_next = S_ABORT;
         end
         S_ABORT: begin
            if (!w_owner_cyc)
               w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // State, priority pointer, owner and registered grant vector
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ptr   <= 1'b0;
         r_owner <= 1'b0;
         r_grant <= 2'b00;
      end else begin
         r_state <= w_next;
         if (w_next == S_GNT0)
            r_grant <= 2'b01;
         else if (w_next == S_GNT1)
            r_grant <= 2'b10;
         else
            r_grant <= 2'b00;
         if (r_state == S_IDLE && w_next == S_GNT0) begin
            r_ptr   <= 1'b1;
            r_owner <= 1'b0;
         end else if (r_state == S_IDLE && w_next == S_GNT1) begin
            r_ptr   <= 1'b0;
            r_owner <= 1'b1;
         end
      end
   end

   // Slave-side mux and ack routing; everything quiet outside GNTx
   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_adr_o  = '0;
      s_dat_o  = '0;
      m0_ack_o = 1'b0;
      m1_ack_o = 1'b0;
      unique case (r_state)
         S_GNT0: begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            m0_ack_o = s_ack_i;
         end
         S_GNT1: begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            m1_ack_o = s_ack_i;
         end
         default: begin
         end
      endcase
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] r_cnt;
   logic          w_stall;
   logic          w_gnt_evt;
   logic          r_err0;
   logic          r_err1;

   assign w_stall   = (r_state == S_GNT0 || r_state == S_GNT1) &&
                      s_stb_o && !s_ack_i;
   assign w_timeout = w_stall && (r_cnt == C_LAST);
   assign w_gnt_evt = (r_state == S_IDLE) && (w_next != S_IDLE);
   assign m0_err_o  = r_err0;
   assign m1_err_o  = r_err1;

   // Count stalled beats; restart on every new grant or slave ack
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (w_gnt_evt || s_ack_i || w_timeout)
         r_cnt <= '0;
      else if (w_stall)
         r_cnt <= r_cnt + 1'b1;
   end

   // One-cycle error pulse to the owner on entry to ABORT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err0 <= 1'b0;
         r_err1 <= 1'b0;
      end else begin
         r_err0 <= (r_state == S_GNT0) && (w_next == S_ABORT);
         r_err1 <= (r_state == S_GNT1) && (w_next == S_ABORT);
      end
   end
`else
   logic w_unused_cfg;

   assign w_timeout    = 1'b0;
   assign m0_err_o     = 1'b0;
   assign m1_err_o     = 1'b0;
   assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule
